// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce FSM, optional auto-repeat
// (define KEY_AUTOREPEAT_EN). The release pulse is named key_release since 'release' is reserved.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press,
    output logic key_release,
    output logic pressed,
    output logic rpt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sync0, sync1, key_s;
    logic          press_nxt, release_nxt, rpt_hit;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debouncer: illegal timing parameters");
    end

    // Flops reset to 'released' so a key held through reset is debounced afresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= key_n;
            sync1 <= sync0;
        end
    end

    assign key_s   = ~sync1;
    assign pressed = (state == PRESSED) || (state == RELEASE_WAIT);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    press_nxt = rpt_hit;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press       <= press_nxt;
            key_release <= release_nxt;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = ($clog2(RMAX) > 0) ? $clog2(RMAX) : 1;

    logic [RW-1:0] rcnt, rlast;
    logic          rarmed;

    // First interval is the long delay; once armed, the shorter period applies.
    assign rlast   = rarmed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign rpt_hit = (state == PRESSED) && key_s && (rcnt == rlast);

    always_ff @(posedge clk) begin
        if (rst || state != PRESSED || !key_s) begin
            rcnt   <= '0;
            rarmed <= 1'b0;
        end else if (rpt_hit) begin
            rcnt   <= '0;
            rarmed <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rpt <= 1'b0;
        else     rpt <= rpt_hit;
    end
`else
    assign rpt_hit = 1'b0;
    assign rpt     = 1'b0;
`endif
endmodule

// File: doc/key_debouncer.md
# key_debouncer

Conditions one active-low push-button (KEY0/KEY1 on the board) into clean single-cycle events for the lab top levels. It sits directly upstream of the reset/translate logic in the lab top level: its `press` pulse drives that block's `set`/translate strobe, and its `pressed` level can drive `rst`. It replaces the ad-hoc two-register edge detector with synchronisation, counter-based debouncing and an optional auto-repeat.

## Interface
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal minimum 2.
- `REPEAT_DELAY`, 25000000, cycles in PRESSED before the first auto-repeat (used only with the macro).
- `REPEAT_PERIOD`, 5000000, cycles between subsequent auto-repeats (used only with the macro).

Ports:
- `clk` input 1, system clock; the only clock.
- `rst` input 1, reset; synchronous, active-high.
- `key_n` input 1, raw button, asynchronous, low = pushed.
- `press` output 1, one-cycle pulse on an accepted press (and on each auto-repeat).
- `release` output 1, one-cycle pulse on an accepted release.
- `pressed` output 1, debounced level, high in PRESSED and RELEASE_WAIT.
- `rpt` output 1, high together with `press` only when that pulse is an auto-repeat.

## Operation
- Synchroniser: two flops on `key_n`; `key_s` = inverted second flop (1 = pushed). Both flops reset to 1 (released).
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES)`; cleared on every state change and whenever the awaited level is lost.
- FSM states and transitions:
  - IDLE: `key_s`=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: `key_s`=0 -> IDLE. `key_s`=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED and `press` asserted. Otherwise cnt++.
  - PRESSED: `key_s`=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: `key_s`=1 -> PRESSED with no new `press`. `key_s`=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE and `release` asserted. Otherwise cnt++.
- `press`, `release` and `rpt` are registered. Each pulse lasts exactly one cycle. `press` and `release` are never high in the same cycle.
- Bounces shorter than DEBOUNCE_CYCLES produce no output activity.
- Reset values: state IDLE, counters 0, `press`=`release`=`pressed`=`rpt`=0.
- Reset mid-operation: returns to IDLE immediately with no `release` pulse. A key still held when `rst` drops is debounced as a fresh press.

## Timing
- Edge 0 is the first `clk` edge that samples `key_n` low, with the input stable from then on.
- `key_s` rises after edge 1. PRESS_WAIT is entered at edge 2.
- `press` is high during the cycle after edge DEBOUNCE_CYCLES+2. `pressed` rises on the same edge.
- Release latency is the same: `release` is high during the cycle after edge DEBOUNCE_CYCLES+2, counted from the first edge sampling `key_n` high. `pressed` falls on that edge.
- `rst` has priority over all other behaviour on the same edge.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - A repeat counter runs in PRESSED.
  - After REPEAT_DELAY cycles in PRESSED, `press` and `rpt` pulse together for one cycle.
  - Further pulses follow every REPEAT_PERIOD cycles while the state remains PRESSED.
  - The repeat counter clears on leaving PRESSED, including a bounce into RELEASE_WAIT, and on `rst`.
- `KEY_AUTOREPEAT_EN` undefined: no repeat counter is synthesised, `rpt` is tied to 0, and exactly one `press` is produced per accepted press.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4. Auto-repeat scenarios use REPEAT_DELAY=10 and REPEAT_PERIOD=3.
- Clean press: `key_n` low from edge 0 -> `press`=1 only in the cycle after edge 6, `pressed`=1 from edge 6 on, `release` stays 0.
- Bounce rejection: `key_n` low 3 cycles, high 1, low 3, high -> no `press` and `pressed` stays 0. Then a 6-cycle-stable low -> exactly one `press`.
- Clean release: held key, `key_n` high at edge 0 -> `release` pulses after edge 6, `pressed` falls at edge 6. A 2-cycle high glitch inside a hold gives no `release` and no second `press`.
- Reset mid-hold: assert `rst` while PRESSED -> all outputs 0 on the next edge with no `release`. Deassert `rst` with the key held -> `press` 6 edges after the first post-reset edge.
- Auto-repeat (macro on): hold the key -> `press` after edge 6, then `press`+`rpt` after edges 16, 19, 22, and so on. Releasing the key stops repeats.
- Macro off: same hold as the auto-repeat scenario -> a single `press`, with `rpt` constantly 0.
